// File: rtl/wb_stage.sv
// Write-back stage: retires ALU ops straight to the register bank and performs
// the data-memory handshake for loads/stores, stalling EX while an access is pending.
module wb_stage #(
  parameter int DATA_W  = 16,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [SEL_W-1:0]  in_dest,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_store,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              BR_Hab_Escrita,
  output logic [SEL_W-1:0]  BR_Sel_E_SA,
  output logic [DATA_W-1:0] entrada_ULA,
  output logic [DATA_W-1:0] entrada_MD,
  output logic              controle,
  output logic              erro
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_ALU   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next, cnt_inc;
  logic                req_reg, req_next;
  logic                we_reg, we_next;
  logic [DATA_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [SEL_W-1:0]    dest_reg, dest_next;
  logic                hab_reg, hab_next;
  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic [DATA_W-1:0]   ula_reg, ula_next;
  logic [DATA_W-1:0]   md_reg, md_next;
  logic                ctl_reg, ctl_next;
  logic                erro_reg, erro_next;

  assign in_ready = (state_reg != MEM);
  assign cnt_inc  = cnt_reg + CNT_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      dest_reg  <= '0;
      hab_reg   <= 1'b0;
      sel_reg   <= '0;
      ula_reg   <= '0;
      md_reg    <= '0;
      ctl_reg   <= 1'b0;
      erro_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      req_reg   <= req_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      dest_reg  <= dest_next;
      hab_reg   <= hab_next;
      sel_reg   <= sel_next;
      ula_reg   <= ula_next;
      md_reg    <= md_next;
      ctl_reg   <= ctl_next;
      erro_reg  <= erro_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_next   = req_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    dest_next  = dest_reg;
    hab_next   = 1'b0;
    sel_next   = sel_reg;
    ula_next   = ula_reg;
    md_next    = md_reg;
    ctl_next   = ctl_reg;
    erro_next  = erro_reg;

    case (state_reg)
      MEM: begin
        // An ack in the final counted cycle still completes normally.
        if (mem_ack) begin
          req_next = 1'b0;
          if (!we_reg) begin
            state_next = WB;
            hab_next   = 1'b1;
            sel_next   = dest_reg;
            md_next    = mem_rdata;
            ctl_next   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          req_next   = 1'b0;
          erro_next  = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        if (in_valid) begin
          if (in_op == OP_ALU) begin
            state_next = WB;
            hab_next   = 1'b1;
            sel_next   = in_dest;
            ula_next   = in_alu;
            ctl_next   = 1'b0;
          end else if (in_op == OP_LOAD || in_op == OP_STORE) begin
            state_next = MEM;
            cnt_next   = '0;
            req_next   = 1'b1;
            we_next    = (in_op == OP_STORE);
            addr_next  = in_alu;
            wdata_next = in_store;
            dest_next  = in_dest;
          end
        end
      end
    endcase
  end

  assign mem_req        = req_reg;
  assign mem_we         = we_reg;
  assign mem_addr       = addr_reg;
  assign mem_wdata      = wdata_reg;
  assign BR_Hab_Escrita = hab_reg;
  assign BR_Sel_E_SA    = sel_reg;
  assign entrada_ULA    = ula_reg;
  assign entrada_MD     = md_reg;
  assign controle       = ctl_reg;
  assign erro           = erro_reg;

endmodule
